lr_serializer: RTL and testbench
================================

Name: lr_serializer

Overview:
- Parallel-in, serial-out 8-bit word transmitter; the transmit end of the bidirectional serial-in shift register already in the design.
- Accepts a word through a load/ready handshake and emits one bit per enabled clock.
- Bit order is chosen per frame so the receiving shift register, running with the same RL setting, holds the original word after WIDTH shifts.
- Sits between a word producer (controller/FSM) and the serial link.

Parameters:
WIDTH, 8, word length in bits (>= 2); bit counter is $clog2(WIDTH) bits wide.

Ports:
Clk  input  1  clock; all state changes on the rising edge
Reset  input  1  synchronous, active-low reset (sampled on rising Clk edge)
Data  input  WIDTH  parallel word to transmit
Load  input  1  request to accept Data; accepted only when Ready=1
RL  input  1  direction; 0 = LSB first (pairs with receiver RL=0), 1 = MSB first (pairs with receiver RL=1); sampled at load
En  input  1  shift tick; one bit consumed per rising edge with En=1 while busy
Ready  output  1  block is idle and can accept Load
Out  output  1  current serial bit
Out_valid  output  1  Out carries a frame bit; drives receiver En together with En
Done  output  1  one-cycle pulse after the final bit of a frame is consumed

Behaviour:
- Reset (Reset=0 at a rising edge): state IDLE, shift register 0, bit counter 0, latched direction 0, Done=0. Outputs are then Ready=1, Out_valid=0, Out=0. Reset overrides every other input.
- States: IDLE, SHIFT.
- IDLE:
  - Ready=1, Out_valid=0, Out=0.
  - Load=1 at an edge: capture Data into the shift register, latch RL, clear the counter, go to SHIFT.
  - En is ignored in IDLE, including an En in the same cycle as Load.
- SHIFT:
  - Ready=0, Out_valid=1.
  - Out is combinational from the register: shreg[0] if the latched direction is 0, shreg[WIDTH-1] if it is 1.
  - The first bit is valid in the cycle after the load edge.
- Edge in SHIFT with En=1:
  - Shift the register toward the output end; the vacated bit fills with 0.
  - Counter increments.
  - If the counter was WIDTH-1, go to IDLE and assert Done for exactly the next cycle.
- Edge in SHIFT with En=0: all state holds; Out is stable.
- Frame length: exactly WIDTH En-qualified edges. With En tied high, Done is high 1+WIDTH cycles after the load edge.
- Back-to-back frames: Ready=1 in the same cycle Done=1. A Load at the following edge starts the next frame, giving a one-cycle gap.
- Load while in SHIFT: ignored; Data is not sampled and the frame is unaffected.
- RL changes mid-frame: ignored; only the latched direction is used.
- Reset mid-frame: the frame is aborted, no Done is produced, and the block returns to the reset state.
- Done is registered and never asserts without a completed frame.

Decomposition:
- Shared package: state enum typedef (IDLE, SHIFT) and the direction constants DIR_LSB_FIRST=0, DIR_MSB_FIRST=1. These are reused by the receiver-side controller.
- No sub-module required. The bit counter stays inline. A loopback wrapper (lr_serializer feeding the existing shift register) is a bench-only structure, not RTL.

Test Plan:
- Reset=0 for 2 cycles, then 1: Ready=1, Out_valid=0, Out=0, Done=0.
- Data=8'h1E, RL=0, Load one cycle, En=1 constant: Out = 0,1,1,1,1,0,0,0 on 8 consecutive cycles; Done pulses once in cycle 9 after the load edge; Ready=1 in that cycle.
- Data=8'h1E, RL=1, En=1: Out = 0,0,0,1,1,1,1,0. Loopback into the receiver (In=Out, En=Out_valid&En, same RL) yields word=8'h1E for both RL=0 and RL=1.
- Data=8'hB4, RL=0, En toggling 1,0,1,0...: each bit holds 2 cycles; Done appears after the 8th En-high edge; Load=1 with Data=8'hFF mid-frame is ignored (receiver still gets 8'hB4).
- Back-to-back frames 8'h01 then 8'h80 (RL=0), Load reasserted in the Done cycle: second frame starts the next edge; Out = 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1.
- Reset=0 after the 3rd bit of 8'hFF: next cycle Out_valid=0, Ready=1, no Done; a new frame 8'h0F then transmits correctly.

Source files
------------

// File: rtl/lr_serializer_pkg.sv
// Shared definitions for the serial link: serializer state encoding and the
// direction constants that the receiver-side controller also uses.
package lr_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/lr_serializer.sv
// Parallel-in, serial-out word transmitter with a load/ready handshake.
// Bit order per frame matches the receiving shift register's RL setting.
module lr_serializer
  import lr_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Data,
  input  logic             Load,
  input  logic             RL,
  input  logic             En,
  output logic             Ready,
  output logic             Out,
  output logic             Out_valid,
  output logic             Done
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  ser_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic             done_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LSB_FIRST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Load) begin
            shreg_q <= Data;
            dir_q   <= RL;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (En) begin
            // Shift toward whichever end is currently driving Out.
            if (dir_q == DIR_MSB_FIRST) begin
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
              shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    Ready     = (state_q == IDLE);
    Out_valid = (state_q == SHIFT);
    Out       = 1'b0;
    if (state_q == SHIFT) begin
      Out = (dir_q == DIR_MSB_FIRST) ? shreg_q[WIDTH-1] : shreg_q[0];
    end
  end

  assign Done = done_q;

endmodule

// File: tb/tb_lr_serializer.sv
// Self-checking bench for lr_serializer: expected bit streams come from the
// word and direction directly, and a bench-side receiver checks loopback.
module tb_lr_serializer;

  localparam int unsigned W = 8;

  logic         Clk;
  logic         Reset;
  logic [W-1:0] Data;
  logic         Load;
  logic         RL;
  logic         En;
  logic         Ready;
  logic         Out;
  logic         Out_valid;
  logic         Done;

  int total = 0;
  int bad   = 0;

  logic         rx_rl;
  logic [W-1:0] rx_word;

  lr_serializer #(.WIDTH(W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Data      (Data),
    .Load      (Load),
    .RL        (RL),
    .En        (En),
    .Ready     (Ready),
    .Out       (Out),
    .Out_valid (Out_valid),
    .Done      (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Loopback receiver: bidirectional shift register with the same RL setting.
  always @(posedge Clk) begin
    if (Out_valid && En) begin
      if (rx_rl) rx_word <= {rx_word[W-2:0], Out};
      else       rx_word <= {Out, rx_word[W-1:1]};
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Load = 1'b1; En = 1'b1; RL = 1'b1; Data = 8'hA5;
    tick(); tick();
    total++;
    if (Ready !== 1'b1 || Out_valid !== 1'b0 || Out !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: Ready=%b Out_valid=%b Out=%b Done=%b, required 1 0 0 0",
               Ready, Out_valid, Out, Done);
    end
    Reset = 1'b1; Load = 1'b0; En = 1'b0;
    tick();
    total++;
    if (Ready !== 1'b1 || Out_valid !== 1'b0 || Out !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: Ready=%b Out_valid=%b Out=%b Done=%b, required 1 0 0 0",
               Ready, Out_valid, Out, Done);
    end
  endtask

  task automatic load_word(input logic [W-1:0] d, input logic rl);
    int guard = 0;
    while (Ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    total++;
    if (Ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: Ready=%b after %0d cycles, required 1", Ready, guard);
    end
    Data  = d;
    RL    = rl;
    Load  = 1'b1;
    En    = 1'($urandom % 2);
    rx_rl = rl;
    tick();
    Load  = 1'b0;
  endtask

  // Runs one frame from the cycle after the load edge; returns in the Done cycle.
  // mode: 0 = En held high, 1 = En toggling starting high, 2 = random En.
  task automatic stream_frame(input logic [W-1:0] d, input logic rl,
                              input int mode, input bit noise);
    int   k   = 0;
    int   cyc = 1;
    bit   en_now;
    logic exp_bit;
    while (k < int'(W) && cyc < 200) begin
      case (mode)
        0:       en_now = 1'b1;
        1:       en_now = (cyc % 2 == 1);
        default: en_now = 1'($urandom % 2);
      endcase
      En = en_now;
      if (noise) begin
        Load = 1'b1;
        Data = W'($urandom);
        RL   = ~rl;
      end
      exp_bit = rl ? d[int'(W) - 1 - k] : d[k];
      total++;
      if (Out !== exp_bit || Out_valid !== 1'b1 || Ready !== 1'b0 || Done !== 1'b0) begin
        bad++;
        $display("FAIL bit%0d word=%h rl=%b: Out=%b Out_valid=%b Ready=%b Done=%b, required %b 1 0 0",
                 k, d, rl, Out, Out_valid, Ready, Done, exp_bit);
      end
      tick();
      cyc++;
      if (en_now) k++;
    end
    Load = 1'b0;
    En   = 1'($urandom % 2);
    total++;
    if (k != int'(W)) begin
      bad++;
      $display("FAIL frame_timeout word=%h: consumed %0d bits, required %0d", d, k, W);
    end
    total++;
    if (Done !== 1'b1 || Ready !== 1'b1 || Out_valid !== 1'b0 || Out !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle word=%h: Done=%b Ready=%b Out_valid=%b Out=%b, required 1 1 0 0",
               d, Done, Ready, Out_valid, Out);
    end
    if (mode == 0) begin
      total++;
      if (cyc != int'(W) + 1) begin
        bad++;
        $display("FAIL done_latency: %0d cycles after load, required %0d", cyc, W + 1);
      end
    end
    total++;
    if (rx_word !== d) begin
      bad++;
      $display("FAIL loopback rl=%b: received %h, required %h", rl, rx_word, d);
    end
  endtask

  task automatic check_done_clears();
    tick();
    total++;
    if (Done !== 1'b0 || Out_valid !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: Done=%b Out_valid=%b one cycle later, required 0 0", Done, Out_valid);
    end
  endtask

  task automatic test_basic_lsb_msb();
    load_word(8'h1E, 1'b0);
    stream_frame(8'h1E, 1'b0, 0, 1'b0);
    check_done_clears();
    load_word(8'h1E, 1'b1);
    stream_frame(8'h1E, 1'b1, 0, 1'b0);
    check_done_clears();
  endtask

  task automatic test_en_toggle_load_ignored();
    load_word(8'hB4, 1'b0);
    stream_frame(8'hB4, 1'b0, 1, 1'b1);
    check_done_clears();
  endtask

  task automatic test_back_to_back();
    load_word(8'h01, 1'b0);
    stream_frame(8'h01, 1'b0, 0, 1'b0);
    load_word(8'h80, 1'b0);
    stream_frame(8'h80, 1'b0, 0, 1'b0);
    check_done_clears();
  endtask

  task automatic test_reset_mid_frame();
    load_word(8'hFF, 1'b0);
    En = 1'b1;
    tick(); tick(); tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    En    = 1'b0;
    total++;
    if (Out_valid !== 1'b0 || Ready !== 1'b1 || Done !== 1'b0 || Out !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: Out_valid=%b Ready=%b Done=%b Out=%b, required 0 1 0 0",
               Out_valid, Ready, Done, Out);
    end
    En = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (Done !== 1'b0 || Out_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done cycle%0d: Done=%b Out_valid=%b, required 0 0", i, Done, Out_valid);
      end
    end
    load_word(8'h0F, 1'b0);
    stream_frame(8'h0F, 1'b0, 0, 1'b0);
    check_done_clears();
  endtask

  task automatic test_random_frames();
    logic [W-1:0] d;
    logic         rl;
    bit           chain = 1'b0;
    for (int f = 0; f < 24; f++) begin
      d  = W'($urandom);
      rl = 1'($urandom % 2);
      if (!chain) begin
        for (int g = 0; g < int'($urandom % 3); g++) tick();
      end
      load_word(d, rl);
      stream_frame(d, rl, int'($urandom % 3), 1'($urandom % 2));
      chain = 1'($urandom % 2);
      if (!chain) check_done_clears();
    end
    check_done_clears();
  endtask

  initial begin
    Reset = 1'b0; Data = '0; Load = 1'b0; RL = 1'b0; En = 1'b0;
    rx_rl = 1'b0;
    test_reset();
    test_basic_lsb_msb();
    test_en_toggle_load_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
